// File: rtl/ifid_decode_queue.sv
// ifid_decode_queue
// -----------------------------------------------------------------------------
// Instruction queue between fetch (IF) and decode (ID). Fetched instructions
// are stored with their PCs in a DEPTH-entry FIFO. The head entry is decoded
// combinationally into RV32 fields plus a format-selected, sign-extended
// immediate. Both sides use valid/ready handshakes; flush clears the queue
// on a branch/jump redirect.
//
// Optional build macro: IFID_ILLEGAL_CHECK_EN adds the 'illegal' output.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous queue clear (priority over push/pop)
//   in_valid/in_ready fetch-side handshake, in_instr/in_pc payload
//   out_valid/out_ready decode-side handshake, out_pc head PC
//   opcode..funct7    decoded head fields, zero while out_valid=0
//   imm, imm_fmt      immediate and its format (0 none,1 I,2 S,3 B,4 U,5 J)
//   count             current occupancy
//   illegal           (IFID_ILLEGAL_CHECK_EN only) head is not legal RV32I
// -----------------------------------------------------------------------------
module ifid_decode_queue #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [2:0]       funct3,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [6:0]       funct7,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       imm_fmt,
    output logic [CNT_W-1:0] count
`ifdef IFID_ILLEGAL_CHECK_EN
    ,
    output logic             illegal
`endif
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    // Immediate format implied by the opcode.
    function automatic logic [2:0] fmt_of(input logic [6:0] op);
        logic [2:0] f;
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: f = FMT_I;
            7'b0100011:                                     f = FMT_S;
            7'b1100011:                                     f = FMT_B;
            7'b0110111, 7'b0010111:                         f = FMT_U;
            7'b1101111:                                     f = FMT_J;
            default:                                        f = FMT_NONE;
        endcase
        return f;
    endfunction

    // Sign-extended immediate assembled according to its format.
    function automatic logic [31:0] imm_of(input logic [31:0] i, input logic [2:0] f);
        logic [31:0] v;
        case (f)
            FMT_I:   v = {{20{i[31]}}, i[31:20]};
            FMT_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   v = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            FMT_U:   v = {i[31:12], 12'h000};
            FMT_J:   v = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    logic [XLEN-1:0]  r_instr [DEPTH];
    logic [PC_W-1:0]  r_pc    [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_head;

    // in_ready deliberately ignores out_ready: a full queue never accepts.
    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != {CNT_W{1'b0}});
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = r_count;

    // FIFO storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= {XLEN{1'b0}};
                r_pc[i]    <= {PC_W{1'b0}};
            end
        end else if (flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_instr[r_wr_ptr] <= in_instr;
                r_pc[r_wr_ptr]    <= in_pc;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1'b1);
                2'b01:   r_count <= r_count - CNT_W'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head decode; an empty queue presents an all-zero word, which decodes
    // to all-zero fields and FMT_NONE.
    always_comb begin
        w_head = 32'h0000_0000;
        out_pc = {PC_W{1'b0}};
        if (out_valid) begin
            w_head = 32'(r_instr[r_rd_ptr]);
            out_pc = r_pc[r_rd_ptr];
        end else begin
            w_head = 32'h0000_0000;
            out_pc = {PC_W{1'b0}};
        end
        opcode  = w_head[6:0];
        rd      = w_head[11:7];
        funct3  = w_head[14:12];
        rs1     = w_head[19:15];
        rs2     = w_head[24:20];
        funct7  = w_head[31:25];
        imm_fmt = fmt_of(w_head[6:0]);
        imm     = XLEN'(imm_of(w_head, imm_fmt));
    end

`ifdef IFID_ILLEGAL_CHECK_EN
    logic w_known_op;
    logic w_bad_r;

    // Legality of the head instruction against the RV32I opcode set.
    always_comb begin
        w_known_op = (fmt_of(w_head[6:0]) != FMT_NONE) ||
                     (w_head[6:0] == 7'b0110011) || (w_head[6:0] == 7'b0001111);
        w_bad_r    = (w_head[6:0] == 7'b0110011) &&
                     (w_head[31:25] != 7'b0000000) && (w_head[31:25] != 7'b0100000);
        illegal    = out_valid &&
                     ((w_head[1:0] != 2'b11) || !w_known_op || w_bad_r);
    end
`endif

endmodule

// File: tb/tb_ifid_decode_queue.sv
module tb_ifid_decode_queue;
    localparam int DEPTH = 4;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, imm;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3, imm_fmt;
    logic [2:0]  count;
`ifdef IFID_ILLEGAL_CHECK_EN
    logic        illegal;
`endif

    int n_vec = 0;
    int n_bad = 0;
    logic [63:0] q[$];   // {pc, instr}, head at q[0]

    ifid_decode_queue #(.XLEN(32), .PC_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .imm_fmt(imm_fmt), .count(count)
`ifdef IFID_ILLEGAL_CHECK_EN
        , .illegal(illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference immediate: value of the scattered field, interpreted as a number.
    function automatic void ref_dec(input logic [31:0] i, output logic [31:0] e_imm,
                                    output logic [2:0] e_fmt);
        logic signed [11:0] s12;
        logic signed [19:0] s20;
        logic [31:0]        u;
        int                 v;
        v = 0;
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                e_fmt = 3'd1; s12 = i[31:20]; v = s12;
            end
            7'b0100011: begin e_fmt = 3'd2; s12 = {i[31:25], i[11:7]}; v = s12; end
            7'b1100011: begin
                e_fmt = 3'd3; s12 = {i[31], i[7], i[30:25], i[11:8]}; v = s12 * 2;
            end
            7'b0110111, 7'b0010111: begin
                e_fmt = 3'd4; u = {12'h000, i[31:12]}; v = int'(u * 32'd4096);
            end
            7'b1101111: begin
                e_fmt = 3'd5; s20 = {i[31], i[19:12], i[20], i[30:21]}; v = s20 * 2;
            end
            default: begin e_fmt = 3'd0; v = 0; end
        endcase
        e_imm = v;
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] hi, hp, e_imm;
        logic [2:0]  e_fmt;
        bit          ev;
        ev = (q.size() != 0);
        hi = ev ? q[0][31:0] : 32'h0;
        hp = ev ? q[0][63:32] : 32'h0;
        ref_dec(hi, e_imm, e_fmt);
        chk({tag, ".out_valid"}, out_valid, ev);
        chk({tag, ".in_ready"},  in_ready, q.size() != DEPTH);
        chk({tag, ".count"},     count, q.size());
        chk({tag, ".out_pc"},    out_pc, hp);
        chk({tag, ".fields"}, {opcode, rd, funct3, rs1, rs2, funct7[6:2]},
            {hi[6:0], hi[11:7], hi[14:12], hi[19:15], hi[24:20], hi[31:27]});
        chk({tag, ".funct7lo"},  funct7[1:0], hi[26:25]);
        chk({tag, ".imm"},       imm, e_imm);
        chk({tag, ".imm_fmt"},   imm_fmt, e_fmt);
`ifdef IFID_ILLEGAL_CHECK_EN
        chk({tag, ".illegal"}, illegal, ev && ((hi[1:0] != 2'b11) ||
            !(hi[6:0] inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011,
                              7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                              7'b1101111, 7'b0110011, 7'b0001111}) ||
            ((hi[6:0] == 7'b0110011) && !(hi[31:25] inside {7'b0000000, 7'b0100000}))));
`endif
    endtask

    // One clock: drive inputs mid-cycle, update the model at the edge, check after.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic rdy, input logic fl);
        bit pu, po;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            pu = v && (q.size() != DEPTH);
            po = rdy && (q.size() != 0);
            if (po) void'(q.pop_front());
            if (pu) q.push_back({pc, ins});
        end
        #1;
        check_all(tag);
    endtask

    logic [6:0] ops [13] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011,
                             7'b0001111, 7'b1010101, 7'b0000000};

    initial begin
        logic [31:0] ri;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0;
        #3;
        chk("reset.out_valid", out_valid, 32'd0);
        chk("reset.in_ready", in_ready, 32'd1);
        chk("reset.count", count, 32'd0);
        chk("reset.imm", imm, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // addi x1,x0,5
        step("addi", 1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
        chk("addi.imm_k", imm, 32'h00000005);
        chk("addi.fmt_k", imm_fmt, 32'd1);
        chk("addi.rd_k", rd, 32'd1);
        step("addi.pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        // sw, beq, lui each presented alone at the head
        step("sw", 1'b1, 32'hFE20AE23, 32'h4, 1'b0, 1'b0);
        chk("sw.imm_k", imm, 32'hFFFFFFFC);
        chk("sw.rs_k", {rs1, rs2, 2'b00, funct3}, {5'd1, 5'd2, 2'b00, 3'd2});
        step("sw.pop", 1'b1, 32'hFE000CE3, 32'h8, 1'b1, 1'b0);
        chk("beq.imm_k", imm, 32'hFFFFFFF8);
        chk("beq.fmt_k", imm_fmt, 32'd3);
        step("lui", 1'b1, 32'h123452B7, 32'hC, 1'b1, 1'b0);
        chk("lui.imm_k", imm, 32'h12345000);
        chk("lui.rd_k", rd, 32'd5);
        step("lui.pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Fill to DEPTH, reject the fifth, pop once, drain in order
        for (int i = 0; i < DEPTH; i++)
            step("fill", 1'b1, 32'h00000013 | (i << 7), i * 4, 1'b0, 1'b0);
        chk("full.in_ready_k", in_ready, 32'd0);
        chk("full.count_k", count, 32'd4);
        step("full.reject", 1'b1, 32'h00000093, 32'h10, 1'b0, 1'b0);
        step("full.pop_rej", 1'b1, 32'h00000093, 32'h10, 1'b1, 1'b0);
        chk("full.pop_pc_k", out_pc, 32'h4);
        for (int i = 0; i < DEPTH; i++)
            step("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Steady stream: occupancy holds at 1 while pointers wrap
        step("stream0", 1'b1, 32'h00100093, 32'h100, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++)
            step("stream", 1'b1, 32'h00100093 + (i << 20), 32'h100 + i * 4, 1'b1, 1'b0);
        chk("stream.count_k", count, 32'd1);
        step("stream.end", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush beats simultaneous push and pop at count=3
        for (int i = 0; i < 3; i++)
            step("preflush", 1'b1, 32'h00A00513, 32'h200 + i * 4, 1'b0, 1'b0);
        step("flush", 1'b1, 32'h00B00593, 32'h300, 1'b1, 1'b1);
        chk("flush.count_k", count, 32'd0);
        chk("flush.pc_k", out_pc, 32'd0);
        step("flush.after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with two entries queued
        step("prerst", 1'b1, 32'h00500093, 32'h40, 1'b0, 1'b0);
        step("prerst", 1'b1, 32'h00000000, 32'h44, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", out_valid, 32'd0);
        chk("arst.in_ready", in_ready, 32'd1);
        chk("arst.count", count, 32'd0);
        q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        check_all("arst.release");
        step("ill0", 1'b1, 32'h00000000, 32'h0, 1'b0, 1'b0);
        step("ill1", 1'b1, 32'h00500093, 32'h4, 1'b1, 1'b0);
        step("ill2", 1'b1, 32'h40B50533, 32'h8, 1'b1, 1'b0);
        step("ill3", 1'b1, 32'h02B50533, 32'hC, 1'b1, 1'b0);
        step("ill4", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Randomised traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            ri = $urandom;
            if ($urandom_range(0, 7) != 0) ri[6:0] = ops[$urandom_range(0, 12)];
            step("rand", $urandom_range(0, 3) != 0, ri, $urandom & 32'hFFFFFFFC,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
